// File: rtl/uart_axi_bridge.sv
// uart_axi_bridge: AXI4-lite master moving CPU words to/from a UART Lite one polled byte at a time.
module uart_axi_bridge #(
  parameter int WORD_BYTES = 4,
  parameter bit BIG_ENDIAN = 1
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic [8*WORD_BYTES-1:0] req_data,
  output logic                    resp_valid,
  output logic [8*WORD_BYTES-1:0] resp_data,
  output logic                    resp_err,
  output logic [3:0]              uart_axi_araddr,
  output logic                    uart_axi_arvalid,
  input  logic                    uart_axi_arready,
  input  logic [31:0]             uart_axi_rdata,
  input  logic [1:0]              uart_axi_rresp,
  input  logic                    uart_axi_rvalid,
  output logic                    uart_axi_rready,
  output logic [3:0]              uart_axi_awaddr,
  output logic                    uart_axi_awvalid,
  input  logic                    uart_axi_awready,
  output logic [31:0]             uart_axi_wdata,
  output logic [3:0]              uart_axi_wstrb,
  output logic                    uart_axi_wvalid,
  input  logic                    uart_axi_wready,
  input  logic [1:0]              uart_axi_bresp,
  input  logic                    uart_axi_bvalid,
  output logic                    uart_axi_bready
);
  localparam int W = 8*WORD_BYTES;
  typedef enum logic [2:0] {IDLE, ST_A, ST_D, WR, WB, RX_A, RX_D, DONE} state_t;
  state_t state_q, state_d;
  logic [W-1:0] data_q, data_d;
  logic write_q, write_d, err_q, err_d, aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic [1:0] cnt_q, cnt_d, bidx;
  logic [7:0] cur_byte;
  logic r_hs, b_hs, aw_ok, w_ok, last, unused_rdata;
  assign r_hs = uart_axi_rready & uart_axi_rvalid;
  assign b_hs = uart_axi_bready & uart_axi_bvalid;
  assign aw_ok = aw_done_q | (uart_axi_awvalid & uart_axi_awready);
  assign w_ok = w_done_q | (uart_axi_wvalid & uart_axi_wready);
  assign last = cnt_q == 2'(WORD_BYTES-1);
  assign bidx = BIG_ENDIAN ? 2'(WORD_BYTES-1) - cnt_q : cnt_q;
  assign uart_axi_wstrb = 4'b0001;
  assign resp_data = write_q ? '0 : data_q;
  assign resp_err = err_q;
  assign unused_rdata = ^uart_axi_rdata[31:8];
  always_comb begin
    cur_byte = '0;
    for (int k = 0; k < WORD_BYTES; k++) if (bidx == 2'(k)) cur_byte = data_q[8*k +: 8];
  end
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) state_q <= IDLE;
    else state_q <= state_d;
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (req_valid) state_d = ST_A;
      ST_A: if (uart_axi_arready) state_d = ST_D;
      ST_D: if (uart_axi_rvalid) state_d = write_q ? (uart_axi_rdata[3] ? ST_A : WR) : (uart_axi_rdata[0] ? RX_A : ST_A);
      WR:   if (aw_ok && w_ok) state_d = WB;
      WB:   if (uart_axi_bvalid) state_d = last ? DONE : ST_A;
      RX_A: if (uart_axi_arready) state_d = RX_D;
      RX_D: if (uart_axi_rvalid) state_d = last ? DONE : ST_A;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    req_ready = state_q == IDLE;
    resp_valid = state_q == DONE;
    uart_axi_arvalid = state_q == ST_A || state_q == RX_A;
    uart_axi_araddr = state_q == ST_A ? 4'h8 : 4'h0;
    uart_axi_rready = state_q == ST_D || state_q == RX_D;
    uart_axi_awvalid = state_q == WR && !aw_done_q;
    uart_axi_wvalid = state_q == WR && !w_done_q;
    uart_axi_awaddr = state_q == WR ? 4'h4 : 4'h0;
    uart_axi_wdata = state_q == WR ? {24'b0, cur_byte} : 32'b0;
    uart_axi_bready = state_q == WB;
  end
  // Each write channel remembers its own completed handshake until both are done.
  always_comb begin
    data_d = data_q;
    write_d = write_q;
    cnt_d = cnt_q;
    err_d = err_q | (r_hs & |uart_axi_rresp) | (b_hs & |uart_axi_bresp);
    aw_done_d = state_q == WR && aw_ok && !w_ok;
    w_done_d = state_q == WR && w_ok && !aw_ok;
    if (req_valid && req_ready) begin
      data_d = req_write ? req_data : '0;
      write_d = req_write;
      err_d = 1'b0;
      cnt_d = 2'd0;
    end
    if (state_q == RX_D && uart_axi_rvalid)
      for (int k = 0; k < WORD_BYTES; k++) if (bidx == 2'(k)) data_d[8*k +: 8] = uart_axi_rdata[7:0];
    if ((b_hs || (state_q == RX_D && uart_axi_rvalid)) && !last) cnt_d = cnt_q + 2'd1;
  end
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      data_q <= '0;
      write_q <= 1'b0;
      err_q <= 1'b0;
      cnt_q <= 2'd0;
      aw_done_q <= 1'b0;
      w_done_q <= 1'b0;
    end else begin
      data_q <= data_d;
      write_q <= write_d;
      err_q <= err_d;
      cnt_q <= cnt_d;
      aw_done_q <= aw_done_d;
      w_done_q <= w_done_d;
    end
endmodule

// File: tb/tb_uart_axi_bridge.sv
// tb_uart_axi_bridge: big- and little-endian bridges sharing one UART Lite slave model with a byte scoreboard.
module tb_uart_axi_bridge;
  logic clk = 1'b0, rstn = 1'b0;
  always #5 clk = ~clk;
  int checks = 0, errors = 0;
  logic sel = 1'b0, b_req_valid = 1'b0, l_req_valid = 1'b0, req_write = 1'b0;
  logic [31:0] req_data = '0;
  logic b_req_ready, l_req_ready, b_resp_valid, l_resp_valid, b_resp_err, l_resp_err;
  logic [31:0] b_resp_data, l_resp_data, b_wdata, l_wdata, m_wdata;
  logic [3:0] b_araddr, l_araddr, b_awaddr, l_awaddr, b_wstrb, l_wstrb, m_araddr, m_awaddr, m_wstrb;
  logic b_arvalid, l_arvalid, b_rready, l_rready, b_awvalid, l_awvalid, b_wvalid, l_wvalid, b_bready, l_bready;
  logic m_arvalid, m_rready, m_awvalid, m_wvalid, m_bready;
  logic s_arready, s_rvalid = 1'b0, s_awready, s_wready, s_bvalid = 1'b0, got_aw = 1'b0, got_w = 1'b0;
  logic aw_hs, w_hs, a_ok, w_ok;
  logic [31:0] s_rdata = '0, wd_q = '0, wd;
  logic [1:0] s_rresp, s_bresp = 2'b00;
  int aw_wait = 0, w_wait = 0, aw_dly = 0, w_dly = 0, stat_reads = 0, wr_total = 0, full_until = 0, err_at = -1;
  logic [7:0] rx_q[$], exp_wr[$];
  logic [32:0] exp_resp[$];

  uart_axi_bridge #(.WORD_BYTES(4), .BIG_ENDIAN(1)) dut_be (
    .clk(clk), .rstn(rstn), .req_valid(b_req_valid), .req_ready(b_req_ready), .req_write(req_write),
    .req_data(req_data), .resp_valid(b_resp_valid), .resp_data(b_resp_data), .resp_err(b_resp_err),
    .uart_axi_araddr(b_araddr), .uart_axi_arvalid(b_arvalid), .uart_axi_arready(s_arready),
    .uart_axi_rdata(s_rdata), .uart_axi_rresp(s_rresp), .uart_axi_rvalid(s_rvalid), .uart_axi_rready(b_rready),
    .uart_axi_awaddr(b_awaddr), .uart_axi_awvalid(b_awvalid), .uart_axi_awready(s_awready),
    .uart_axi_wdata(b_wdata), .uart_axi_wstrb(b_wstrb), .uart_axi_wvalid(b_wvalid), .uart_axi_wready(s_wready),
    .uart_axi_bresp(s_bresp), .uart_axi_bvalid(s_bvalid), .uart_axi_bready(b_bready));
  uart_axi_bridge #(.WORD_BYTES(4), .BIG_ENDIAN(0)) dut_le (
    .clk(clk), .rstn(rstn), .req_valid(l_req_valid), .req_ready(l_req_ready), .req_write(req_write),
    .req_data(req_data), .resp_valid(l_resp_valid), .resp_data(l_resp_data), .resp_err(l_resp_err),
    .uart_axi_araddr(l_araddr), .uart_axi_arvalid(l_arvalid), .uart_axi_arready(s_arready),
    .uart_axi_rdata(s_rdata), .uart_axi_rresp(s_rresp), .uart_axi_rvalid(s_rvalid), .uart_axi_rready(l_rready),
    .uart_axi_awaddr(l_awaddr), .uart_axi_awvalid(l_awvalid), .uart_axi_awready(s_awready),
    .uart_axi_wdata(l_wdata), .uart_axi_wstrb(l_wstrb), .uart_axi_wvalid(l_wvalid), .uart_axi_wready(s_wready),
    .uart_axi_bresp(s_bresp), .uart_axi_bvalid(s_bvalid), .uart_axi_bready(l_bready));

  assign m_araddr = sel ? l_araddr : b_araddr;
  assign m_arvalid = sel ? l_arvalid : b_arvalid;
  assign m_rready = sel ? l_rready : b_rready;
  assign m_awaddr = sel ? l_awaddr : b_awaddr;
  assign m_awvalid = sel ? l_awvalid : b_awvalid;
  assign m_wdata = sel ? l_wdata : b_wdata;
  assign m_wstrb = sel ? l_wstrb : b_wstrb;
  assign m_wvalid = sel ? l_wvalid : b_wvalid;
  assign m_bready = sel ? l_bready : b_bready;
  assign s_arready = 1'b1;
  assign s_rresp = 2'b00;
  assign s_awready = m_awvalid && aw_wait >= aw_dly;
  assign s_wready = m_wvalid && w_wait >= w_dly;
  assign aw_hs = m_awvalid && s_awready;
  assign w_hs = m_wvalid && s_wready;
  assign a_ok = got_aw || aw_hs;
  assign w_ok = got_w || w_hs;
  assign wd = w_hs ? m_wdata : wd_q;

  // UART Lite model: STAT reports full until full_until reads, RX valid while rx_q has data.
  always @(posedge clk or negedge rstn)
    if (!rstn) begin
      s_rvalid <= 1'b0;
      s_bvalid <= 1'b0;
      got_aw <= 1'b0;
      got_w <= 1'b0;
      aw_wait <= 0;
      w_wait <= 0;
    end else begin
      if (m_arvalid) begin
        s_rvalid <= 1'b1;
        if (m_araddr == 4'h8) begin
          s_rdata <= (stat_reads < full_until) ? 32'h8 : (rx_q.size() != 0 ? 32'h1 : 32'h0);
          stat_reads <= stat_reads + 1;
        end else s_rdata <= rx_q.size() != 0 ? {24'h0, rx_q.pop_front()} : 32'h0;
      end else if (s_rvalid && m_rready) s_rvalid <= 1'b0;
      aw_wait <= (m_awvalid && !s_awready) ? aw_wait + 1 : 0;
      w_wait <= (m_wvalid && !s_wready) ? w_wait + 1 : 0;
      if (s_bvalid && m_bready) s_bvalid <= 1'b0;
      if (a_ok && w_ok) begin
        got_aw <= 1'b0;
        got_w <= 1'b0;
        wr_total <= wr_total + 1;
        s_bvalid <= 1'b1;
        s_bresp <= (wr_total + 1 == err_at) ? 2'b10 : 2'b00;
      end else begin
        got_aw <= a_ok;
        got_w <= w_ok;
        if (w_hs) wd_q <= m_wdata;
      end
    end

  initial forever begin
    @(negedge clk);
    if (!rstn) exp_wr.delete();
    else begin
      if (m_arvalid && m_araddr != 4'h8) begin
        checks++;
        if (m_araddr !== 4'h0) begin errors++; $display("FAIL araddr got %h want 0", m_araddr); end
      end
      if (aw_hs) begin
        checks++;
        if (m_awaddr !== 4'h4) begin errors++; $display("FAIL awaddr got %h want 4", m_awaddr); end
      end
      if (w_hs) begin
        checks++;
        if (m_wstrb !== 4'b0001) begin errors++; $display("FAIL wstrb got %b want 0001", m_wstrb); end
      end
      if (a_ok && w_ok) begin
        checks++;
        if (exp_wr.size() == 0) begin errors++; $display("FAIL wr_byte got unexpected write %h", wd); end
        else if (wd !== {24'h0, exp_wr[0]}) begin errors++; $display("FAIL wr_byte got %h want %h", wd, exp_wr[0]); end
        if (exp_wr.size() != 0) void'(exp_wr.pop_front());
        checks++;
        if (stat_reads <= full_until) begin errors++; $display("FAIL wr_while_full stat_reads %0d want > %0d", stat_reads, full_until); end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  function automatic void push_wr(input logic [31:0] d);
    for (int i = 3; i >= 0; i--) exp_wr.push_back(d[8*i +: 8]);
  endfunction

  task automatic do_req(input bit le, input bit wr, input logic [31:0] d, input logic [31:0] ed, input bit ee, input int lat);
    int n;
    logic [32:0] e;
    exp_resp.push_back({ee, ed});
    @(negedge clk);
    sel = le;
    req_write = wr;
    req_data = d;
    checks++;
    if ((le ? l_req_ready : b_req_ready) !== 1'b1) begin errors++; $display("FAIL req_ready got 0 want 1"); end
    if (le) l_req_valid = 1'b1; else b_req_valid = 1'b1;
    @(negedge clk);
    l_req_valid = 1'b0;
    b_req_valid = 1'b0;
    for (n = 0; n < 1000 && (le ? l_resp_valid : b_resp_valid) !== 1'b1; n++) @(negedge clk);
    e = exp_resp.pop_front();
    checks++;
    if ((le ? l_resp_valid : b_resp_valid) !== 1'b1) begin errors++; $display("FAIL resp_timeout got no resp_valid"); end
    checks++;
    if ((le ? l_resp_data : b_resp_data) !== e[31:0]) begin errors++; $display("FAIL resp_data got %h want %h", le ? l_resp_data : b_resp_data, e[31:0]); end
    checks++;
    if ((le ? l_resp_err : b_resp_err) !== e[32]) begin errors++; $display("FAIL resp_err got %b want %b", le ? l_resp_err : b_resp_err, e[32]); end
    if (lat >= 0) begin
      checks++;
      if (n != lat) begin errors++; $display("FAIL latency got %0d want %0d", n, lat); end
    end
    @(negedge clk);
    checks++;
    if ((le ? l_resp_valid : b_resp_valid) !== 1'b0 || (le ? l_resp_data : b_resp_data) !== e[31:0])
      begin errors++; $display("FAIL resp_pulse got valid %b data %h want 0 %h", le ? l_resp_valid : b_resp_valid, le ? l_resp_data : b_resp_data, e[31:0]); end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if (b_req_ready !== 1'b1) begin errors++; $display("FAIL rst_req_ready got %b want 1", b_req_ready); end
    checks++;
    if ({b_arvalid, b_rready, b_awvalid, b_wvalid, b_bready, b_resp_valid} !== 6'b0)
      begin errors++; $display("FAIL rst_valids got %b want 000000", {b_arvalid, b_rready, b_awvalid, b_wvalid, b_bready, b_resp_valid}); end
    checks++;
    if ({b_resp_data, b_resp_err, b_araddr, b_awaddr, b_wdata} !== 73'b0)
      begin errors++; $display("FAIL rst_data got %h %b %h %h %h want 0", b_resp_data, b_resp_err, b_araddr, b_awaddr, b_wdata); end
    checks++;
    if (b_wstrb !== 4'b0001) begin errors++; $display("FAIL rst_wstrb got %b want 0001", b_wstrb); end
    rstn = 1'b1;
  endtask

  task automatic test_send();
    int w0 = wr_total;
    push_wr(32'hDEADBEEF);
    do_req(1'b0, 1'b1, 32'hDEADBEEF, 32'h0, 1'b0, 16);
    checks++;
    if (wr_total - w0 != 4 || exp_wr.size() != 0) begin errors++; $display("FAIL send_count got %0d left %0d want 4 0", wr_total - w0, exp_wr.size()); end
  endtask

  task automatic test_tx_full();
    int s0 = stat_reads;
    full_until = stat_reads + 3;
    push_wr(32'h11223344);
    do_req(1'b0, 1'b1, 32'h11223344, 32'h0, 1'b0, 22);
    checks++;
    if (stat_reads - s0 != 7) begin errors++; $display("FAIL stat_reads got %0d want 7", stat_reads - s0); end
  endtask

  task automatic test_receive();
    foreach (rx_q[i]) rx_q[i] = 8'h0;
    rx_q = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    do_req(1'b1, 1'b0, 32'hFFFFFFFF, 32'hD4C3B2A1, 1'b0, 16);
    rx_q = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    do_req(1'b0, 1'b0, 32'h0, 32'hA1B2C3D4, 1'b0, 16);
    checks++;
    if (rx_q.size() != 0) begin errors++; $display("FAIL rx_drain got %0d left want 0", rx_q.size()); end
  endtask

  task automatic test_split_handshake();
    int w0 = wr_total;
    bit hit = 1'b0;
    aw_dly = 2;
    w_dly = 5;
    push_wr(32'h5AC3963C);
    fork
      do_req(1'b0, 1'b1, 32'h5AC3963C, 32'h0, 1'b0, 36);
      begin
        for (int n = 0; n < 100 && !hit; n++) begin @(negedge clk); hit = aw_hs && !w_hs; end
        checks++;
        if (!hit) begin errors++; $display("FAIL split_aw got no early aw handshake"); end
        @(negedge clk);
        checks++;
        if (m_awvalid !== 1'b0 || m_wvalid !== 1'b1) begin errors++; $display("FAIL split_valids got aw %b w %b want 0 1", m_awvalid, m_wvalid); end
      end
    join
    aw_dly = 0;
    w_dly = 0;
    checks++;
    if (wr_total - w0 != 4) begin errors++; $display("FAIL split_count got %0d want 4", wr_total - w0); end
  endtask

  task automatic test_bresp_err();
    int w0 = wr_total;
    err_at = wr_total + 2;
    push_wr(32'h0F1E2D3C);
    do_req(1'b0, 1'b1, 32'h0F1E2D3C, 32'h0, 1'b1, 16);
    err_at = -1;
    checks++;
    if (wr_total - w0 != 4) begin errors++; $display("FAIL err_count got %0d want 4", wr_total - w0); end
  endtask

  task automatic test_reset_mid_write();
    int w0 = wr_total;
    bit seen = 1'b0;
    push_wr(32'hCAFEF00D);
    @(negedge clk);
    sel = 1'b0;
    req_write = 1'b1;
    req_data = 32'hCAFEF00D;
    b_req_valid = 1'b1;
    @(negedge clk);
    b_req_valid = 1'b0;
    for (int n = 0; n < 200 && !(m_awvalid && wr_total - w0 == 2); n++) @(negedge clk);
    checks++;
    if (!(m_awvalid && wr_total - w0 == 2)) begin errors++; $display("FAIL rst_mid_reach got writes %0d want byte 2 in WR", wr_total - w0); end
    rstn = 1'b0;
    #1;
    checks++;
    if (m_awvalid !== 1'b0 || m_wvalid !== 1'b0) begin errors++; $display("FAIL rst_mid_valids got aw %b w %b want 0 0", m_awvalid, m_wvalid); end
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    checks++;
    if (b_req_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_ready got %b want 1", b_req_ready); end
    repeat (40) begin @(negedge clk); if (b_resp_valid) seen = 1'b1; end
    checks++;
    if (seen || wr_total - w0 != 2) begin errors++; $display("FAIL rst_mid_resp got resp %b writes %0d want 0 2", seen, wr_total - w0); end
  endtask

  task automatic test_back_to_back();
    push_wr(32'h01020304);
    do_req(1'b0, 1'b1, 32'h01020304, 32'h0, 1'b0, 16);
    push_wr(32'h8090A0B0);
    do_req(1'b0, 1'b1, 32'h8090A0B0, 32'h0, 1'b0, 16);
  endtask

  initial begin
    test_reset();
    test_send();
    test_tx_full();
    test_receive();
    test_split_handshake();
    test_bresp_err();
    test_reset_mid_write();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
